// File: rtl/pc_seq_if.sv
// Control and status bundle between the fetch controller and the program counter.
interface pc_seq_if #(
    parameter int ADDR_W  = 7,
    parameter int OFF_W   = ADDR_W,
    parameter int DEPTH_W = 3
);
    logic                Up;
    logic                Load;
    logic [ADDR_W-1:0]   Target;
    logic                Branch;
    logic [OFF_W-1:0]    Offset;
    logic                Call;
    logic                Ret;
    logic [ADDR_W-1:0]   address;
    logic [DEPTH_W-1:0]  depth;
    logic                Overflow;
    logic                Underflow;
    logic                RangeErr;

    modport master (
        output Up, Load, Target, Branch, Offset, Call, Ret,
        input  address, depth, Overflow, Underflow, RangeErr
    );

    modport slave (
        input  Up, Load, Target, Branch, Offset, Call, Ret,
        output address, depth, Overflow, Underflow, RangeErr
    );
endinterface

// File: rtl/pc_seq.sv
// Program counter for the instruction-fetch path: increment with wrap limit,
// absolute jump, signed relative branch, and call/return through a small
// return-address stack. Error flags are sticky until Clr.
module pc_seq #(
    parameter int ADDR_W      = 7,
    parameter int LAST_ADDR   = 2**ADDR_W - 1,
    parameter int OFF_W       = ADDR_W,
    parameter int STACK_DEPTH = 4
) (
    input logic     Clock,
    input logic     Clr,
    pc_seq_if.slave bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [ADDR_W-1:0]  LAST  = ADDR_W'(LAST_ADDR);
    // One extra bit keeps the range compare meaningful when LAST is all ones.
    localparam logic [ADDR_W:0]    LIMIT = {1'b0, LAST};
    localparam logic [DEPTH_W-1:0] FULL  = DEPTH_W'(STACK_DEPTH);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, unf_q, rng_q;
    logic               set_ovf, set_unf, set_rng;
    logic               push;
    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
    logic [ADDR_W-1:0]  pc_inc, off_ext, branch_tgt, top_entry;
    logic [IDX_W-1:0]   push_idx, top_idx;

    function automatic logic out_of_range(input logic [ADDR_W-1:0] tgt);
        return {1'b0, tgt} > LIMIT;
    endfunction

    assign pc_inc     = (pc_q == LAST) ? '0 : pc_q + ADDR_W'(1);
    assign off_ext    = ADDR_W'($signed(bus.Offset));
    assign branch_tgt = pc_q + off_ext;
    assign push_idx   = IDX_W'(depth_q);
    assign top_idx    = IDX_W'(depth_q - DEPTH_W'(1));
    assign top_entry  = stack_mem[top_idx];

    // Resolve the single winning action for this cycle: Ret > Call > Load > Branch > Up.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        push    = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_rng = 1'b0;
        if (bus.Ret) begin
            if (depth_q != '0) begin
                pc_d    = top_entry;
                depth_d = depth_q - DEPTH_W'(1);
            end else begin
                set_unf = 1'b1;
            end
        end else if (bus.Call) begin
            if (depth_q == FULL) begin
                set_ovf = 1'b1;
            end else begin
                push    = 1'b1;
                depth_d = depth_q + DEPTH_W'(1);
                if (out_of_range(bus.Target)) begin
                    pc_d    = '0;
                    set_rng = 1'b1;
                end else begin
                    pc_d = bus.Target;
                end
            end
        end else if (bus.Load) begin
            if (out_of_range(bus.Target)) begin
                pc_d    = '0;
                set_rng = 1'b1;
            end else begin
                pc_d = bus.Target;
            end
        end else if (bus.Branch) begin
            if (out_of_range(branch_tgt)) begin
                pc_d    = '0;
                set_rng = 1'b1;
            end else begin
                pc_d = branch_tgt;
            end
        end else if (bus.Up) begin
            pc_d = pc_inc;
        end
    end

    // PC, occupancy and sticky flags; Clr overrides everything.
    always_ff @(posedge Clock) begin
        if (Clr) begin
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_q | set_ovf;
            unf_q   <= unf_q | set_unf;
            rng_q   <= rng_q | set_rng;
        end
    end

    // Return-address storage; contents are don't-care after Clr, so it is not reset.
    always_ff @(posedge Clock) begin
        if (push && !Clr) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    assign bus.address   = pc_q;
    assign bus.depth     = depth_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Underflow = unf_q;
    assign bus.RangeErr  = rng_q;
endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: two instances (full range, and LAST_ADDR=99) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_pc_seq;
    typedef struct {
        bit         clr;
        bit         up;
        bit         load;
        logic [6:0] target;
        bit         branch;
        logic [6:0] offset;
        bit         call;
        bit         ret;
    } in_t;

    typedef struct {
        in_t         stim;
        logic [31:0] exp;
    } vec_t;

    logic Clock = 1'b0;
    logic Clr   = 1'b1;
    in_t  cur;

    int n_total = 0;
    int n_bad   = 0;

    always #5 Clock = ~Clock;

    pc_seq_if #(.ADDR_W(7), .OFF_W(7), .DEPTH_W(3)) bus_a ();
    pc_seq_if #(.ADDR_W(7), .OFF_W(7), .DEPTH_W(3)) bus_b ();

    pc_seq #(.ADDR_W(7)) dut_a (.Clock(Clock), .Clr(Clr), .bus(bus_a));
    pc_seq #(.ADDR_W(7), .LAST_ADDR(99)) dut_b (.Clock(Clock), .Clr(Clr), .bus(bus_b));

    assign bus_a.Up = cur.up;         assign bus_b.Up = cur.up;
    assign bus_a.Load = cur.load;     assign bus_b.Load = cur.load;
    assign bus_a.Target = cur.target; assign bus_b.Target = cur.target;
    assign bus_a.Branch = cur.branch; assign bus_b.Branch = cur.branch;
    assign bus_a.Offset = cur.offset; assign bus_b.Offset = cur.offset;
    assign bus_a.Call = cur.call;     assign bus_b.Call = cur.call;
    assign bus_a.Ret = cur.ret;       assign bus_b.Ret = cur.ret;

    // Behavioural model: plain integers and an array used as a LIFO.
    int m_addr [2];
    int m_dep  [2];
    int m_stk  [2][4];
    bit m_ov   [2];
    bit m_uf   [2];
    bit m_re   [2];

    function automatic int last_of(input int k);
        return (k == 0) ? 127 : 99;
    endfunction

    task automatic m_goto(input int k, input int t);
        if (t > last_of(k)) begin
            m_addr[k] = 0;
            m_re[k]   = 1'b1;
        end else begin
            m_addr[k] = t;
        end
    endtask

    task automatic model_step(input int k, input in_t v);
        int nxt;
        int o;
        nxt = (m_addr[k] == last_of(k)) ? 0 : m_addr[k] + 1;
        if (v.clr) begin
            m_addr[k] = 0; m_dep[k] = 0;
            m_ov[k] = 0; m_uf[k] = 0; m_re[k] = 0;
        end else if (v.ret) begin
            if (m_dep[k] > 0) begin
                m_dep[k]  = m_dep[k] - 1;
                m_addr[k] = m_stk[k][m_dep[k]];
            end else begin
                m_uf[k] = 1'b1;
            end
        end else if (v.call) begin
            if (m_dep[k] == 4) begin
                m_ov[k] = 1'b1;
            end else begin
                m_stk[k][m_dep[k]] = nxt;
                m_dep[k] = m_dep[k] + 1;
                m_goto(k, int'(v.target));
            end
        end else if (v.load) begin
            m_goto(k, int'(v.target));
        end else if (v.branch) begin
            o = int'(v.offset);
            if (o >= 64) o = o - 128;
            m_goto(k, (m_addr[k] + o + 128) % 128);
        end else if (v.up) begin
            m_addr[k] = nxt;
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int d, input bit ov, input bit uf, input bit re);
        return {19'b0, 7'(a), 3'(d), ov, uf, re};
    endfunction

    function automatic logic [31:0] act_a();
        return {19'b0, bus_a.address, bus_a.depth, bus_a.Overflow, bus_a.Underflow, bus_a.RangeErr};
    endfunction

    function automatic logic [31:0] act_b();
        return {19'b0, bus_b.address, bus_b.depth, bus_b.Overflow, bus_b.Underflow, bus_b.RangeErr};
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h (addr<<6|depth<<3|ov,uf,re)", name, act, exp);
        end
    endtask

    task automatic step(input in_t v, input string tag);
        cur = v;
        Clr = v.clr;
        @(posedge Clock);
        model_step(0, v);
        model_step(1, v);
        #1;
        compare({tag, " model A"}, act_a(), pk(m_addr[0], m_dep[0], m_ov[0], m_uf[0], m_re[0]));
        compare({tag, " model B"}, act_b(), pk(m_addr[1], m_dep[1], m_ov[1], m_uf[1], m_re[1]));
    endtask

    function automatic in_t mk(input bit clr, input bit up, input bit load, input int target,
                               input bit branch, input int offset, input bit call, input bit ret);
        in_t v;
        v.clr = clr; v.up = up; v.load = load; v.target = 7'(target);
        v.branch = branch; v.offset = 7'(offset); v.call = call; v.ret = ret;
        return v;
    endfunction

    function automatic in_t op_clr();           return mk(1, 0, 0, 0, 0, 0, 0, 0); endfunction
    function automatic in_t op_up();            return mk(0, 1, 0, 0, 0, 0, 0, 0); endfunction
    function automatic in_t op_load(input int t); return mk(0, 0, 1, t, 0, 0, 0, 0); endfunction
    function automatic in_t op_call(input int t); return mk(0, 0, 0, t, 0, 0, 1, 0); endfunction
    function automatic in_t op_ret();           return mk(0, 0, 0, 0, 0, 0, 0, 1); endfunction
    function automatic in_t op_br(input int o); return mk(0, 0, 0, 0, 1, o, 0, 0); endfunction

    vec_t tbl [18];

    initial begin
        cur = op_clr();

        // Hand-derived expectations for the full-range instance.
        tbl[0]  = '{stim: op_clr(),                      exp: pk(0,   0, 0, 0, 0)};
        tbl[1]  = '{stim: op_load(10),                   exp: pk(10,  0, 0, 0, 0)};
        tbl[2]  = '{stim: op_call(40),                   exp: pk(40,  1, 0, 0, 0)};
        tbl[3]  = '{stim: op_call(60),                   exp: pk(60,  2, 0, 0, 0)};
        tbl[4]  = '{stim: op_ret(),                      exp: pk(41,  1, 0, 0, 0)};
        tbl[5]  = '{stim: op_ret(),                      exp: pk(11,  0, 0, 0, 0)};
        tbl[6]  = '{stim: op_load(5),                    exp: pk(5,   0, 0, 0, 0)};
        tbl[7]  = '{stim: op_br(-7),                     exp: pk(126, 0, 0, 0, 0)};
        tbl[8]  = '{stim: op_load(10),                   exp: pk(10,  0, 0, 0, 0)};
        tbl[9]  = '{stim: mk(0, 1, 0, 0, 1, 3, 0, 0),    exp: pk(13,  0, 0, 0, 0)};
        tbl[10] = '{stim: op_call(20),                   exp: pk(20,  1, 0, 0, 0)};
        tbl[11] = '{stim: op_call(30),                   exp: pk(30,  2, 0, 0, 0)};
        tbl[12] = '{stim: mk(0, 1, 1, 50, 1, 1, 1, 1),   exp: pk(21,  1, 0, 0, 0)};
        tbl[13] = '{stim: op_ret(),                      exp: pk(14,  0, 0, 0, 0)};
        tbl[14] = '{stim: op_ret(),                      exp: pk(14,  0, 0, 1, 0)};
        tbl[15] = '{stim: op_up(),                       exp: pk(15,  0, 0, 1, 0)};
        tbl[16] = '{stim: mk(1, 0, 0, 40, 0, 0, 1, 0),   exp: pk(0,   0, 0, 0, 0)};
        tbl[17] = '{stim: op_call(40),                   exp: pk(40,  1, 0, 0, 0)};

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].stim, "tbl");
            compare($sformatf("tbl[%0d]", i), act_a(), tbl[i].exp);
        end

        // Increment across the wrap point of the full-range instance.
        step(op_clr(), "up_clr");
        for (int i = 0; i < 130; i++) begin
            step(op_up(), "up");
            compare($sformatf("up_wrap[%0d]", i), act_a(), pk((i + 1) % 128, 0, 0, 0, 0));
        end

        // Reduced wrap limit and sticky range error on the LAST_ADDR=99 instance.
        step(op_clr(), "lim_clr");
        step(op_load(98), "lim");
        step(op_up(), "lim");
        compare("lim_99", act_b(), pk(99, 0, 0, 0, 0));
        step(op_up(), "lim");
        compare("lim_wrap", act_b(), pk(0, 0, 0, 0, 0));
        step(op_load(120), "lim");
        compare("lim_range_b", act_b(), pk(0, 0, 0, 0, 1));
        compare("lim_range_a", act_a(), pk(120, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) step(op_up(), "lim");
        compare("lim_sticky", act_b(), pk(3, 0, 0, 0, 1));
        step(op_clr(), "lim_clr2");
        compare("lim_cleared", act_b(), pk(0, 0, 0, 0, 0));

        // Overflow then underflow on a depth-4 stack.
        step(op_load(10), "ovf");
        for (int i = 0; i < 4; i++) step(op_call(20 + 10 * i), "ovf");
        compare("ovf_full", act_a(), pk(50, 4, 0, 0, 0));
        step(op_call(60), "ovf");
        compare("ovf_5th", act_a(), pk(50, 4, 1, 0, 0));
        for (int i = 0; i < 4; i++) begin
            step(op_ret(), "unf");
            compare($sformatf("unf_pop[%0d]", i), act_a(), pk(41 - 10 * i, 3 - i, 1, 0, 0));
        end
        step(op_ret(), "unf");
        compare("unf_5th", act_a(), pk(11, 0, 1, 1, 0));
        step(mk(1, 1, 1, 7, 1, 1, 1, 1), "clr_all");
        compare("clr_all", act_a(), pk(0, 0, 0, 0, 0));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            in_t v;
            v.clr    = ($urandom_range(0, 59) == 0);
            v.up     = 1'($urandom_range(0, 1));
            v.load   = ($urandom_range(0, 7) == 0);
            v.target = 7'($urandom_range(0, 127));
            v.branch = ($urandom_range(0, 5) == 0);
            v.offset = 7'($urandom);
            v.call   = ($urandom_range(0, 4) == 0);
            v.ret    = ($urandom_range(0, 4) == 0);
            step(v, "rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program counter for the instruction-fetch path; successor to the fixed 7-bit clear/increment counter. Adds configurable address width and wrap limit, absolute jump, signed relative branch, and call/return through an internal return-address stack with sticky error flags. Sits between the control FSM and instruction ROM; `address` drives the ROM address directly.

## Interface
- ADDR_W, 7, address width in bits (≥2)
- LAST_ADDR, 2**ADDR_W-1, highest legal address; wrap/range limit (≤ 2**ADDR_W-1)
- OFF_W, ADDR_W, width of signed branch offset (≤ ADDR_W)
- STACK_DEPTH, 4, return-address stack entries (≥1)

- Clock  in  1  single clock; all state changes on posedge
- Clr  in  1  synchronous, active-high reset; sampled on posedge Clock
- Up  in  1  increment enable
- Load  in  1  absolute jump to Target
- Target  in  ADDR_W  jump/call destination
- Branch  in  1  relative branch by Offset
- Offset  in  OFF_W  signed (two's complement) branch offset
- Call  in  1  push return address, jump to Target
- Ret  in  1  pop return address into PC
- address  out  ADDR_W  current PC (registered)
- depth  out  $clog2(STACK_DEPTH+1)  stack occupancy
- Overflow  out  1  sticky: Call attempted with stack full
- Underflow  out  1  sticky: Ret attempted with stack empty
- RangeErr  out  1  sticky: computed jump/branch/call target > LAST_ADDR

## Operation
- Reset (Clr=1 at posedge): address=0, depth=0, Overflow=Underflow=RangeErr=0; stack contents don't-care. Clr overrides all other inputs.
- Priority per cycle when Clr=0: Ret > Call > Load > Branch > Up > hold. Exactly one action per cycle; lower-priority requests that cycle are dropped, not queued.
- Hold: all inputs low -> address and stack unchanged (stall).
- Up: address==LAST_ADDR -> 0, else address+1.
- Load: address <= Target.
- Branch: next = (address + sign_extend(Offset)) mod 2**ADDR_W; negative results wrap modulo 2**ADDR_W before range check.
- Call, depth<STACK_DEPTH: push incremented address (same wrap rule as Up) onto top; address <= Target; depth+1.
- Call, depth==STACK_DEPTH: no push, address unchanged, Overflow <= 1.
- Ret, depth>0: address <= top entry; depth-1.
- Ret, depth==0: address unchanged, Underflow <= 1.
- Range rule (Load, Branch, Call only): if resulting target > LAST_ADDR, address <= 0 and RangeErr <= 1; for Call the push still occurs. Popped values are always legal (pushed with wrap).
- Sticky flags clear only on Clr.
- Stack is LIFO; entries beyond depth are never visible.

## Timing
- All outputs registered; no combinational input-to-output path.
- One-cycle latency: inputs sampled at posedge N, new address/depth/flags visible after posedge N.
- Flags assert in the same cycle as the offending request's effect and stay high.
- Call followed by Ret on the next cycle returns to call-site+1; back-to-back Call/Ret fully supported at one op per cycle.
- Clr asserted mid-sequence (e.g. with Call high) wins: stack emptied, no push recorded.

## Test plan
- Defaults; Clr one cycle, then Up for 130 cycles -> address 0..127, wraps to 0 after 127, reaches 2; flags 0.
- LAST_ADDR=99: Up from 98 -> 99 -> 0; Load Target=120 -> address 0, RangeErr=1, persists until Clr.
- address=5, Branch Offset=-7 (OFF_W=7) -> address 126; address=10, Offset=+3 -> 13; Branch and Up together -> branch wins.
- STACK_DEPTH=4: at address 10 Call Target=40, at 40 Call 60, Ret, Ret -> 60, 41, 11; depth 1,2,1,0.
- Five Calls -> 5th: address unchanged, depth=4, Overflow=1; then five Rets -> 5th: Underflow=1, depth=0.
- Ret and Call asserted together with depth=2 -> pop only, depth=1; Clr with Call high -> address=0, depth=0, all flags 0.
